// File: rtl/add_slice_sequencer.sv
// add_slice_sequencer: splits one WIDTH-bit add (a + b + cin) into 3-bit slices,
// drives an external combinational 3-bit adder one slice per cycle (LSB first),
// carries between slices through a register and returns the assembled sum and
// carry-out on a valid/ready output port.
//
// Handshake semantics (both ports): a transfer happens on a rising edge where
// valid and ready are both 1. in_ready is high only in IDLE (and never during
// reset). out_valid is high only in DONE. Once raised, out_valid stays high with
// stable out_sum/out_cout until the transfer edge.
module add_slice_sequencer #(
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic [2:0]       add_a,
   output logic [2:0]       add_b,
   output logic             add_cin,
   input  logic [2:0]       add_s,
   input  logic             add_cout,
   output logic [1:0]       dbg_state
);

   localparam int SLICES = WIDTH / 3;
   localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               carry_q, carry_d;
   logic               cout_q, cout_d;

   // Next-state logic, slice selection toward the adder and handshake outputs.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      a_d       = a_q;
      b_d       = b_q;
      sum_d     = sum_q;
      carry_d   = carry_q;
      cout_d    = cout_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      add_a     = 3'd0;
      add_b     = 3'd0;
      add_cin   = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = ~rst;
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               carry_d = in_cin;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            add_a   = a_q[3*idx_q +: 3];
            add_b   = b_q[3*idx_q +: 3];
            add_cin = carry_q;
            sum_d[3*idx_q +: 3] = add_s;
            carry_d = add_cout;
            if (idx_q == LAST_IDX) begin
               cout_d  = add_cout;
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any request in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
      end
   end

   assign out_sum   = sum_q;
   assign out_cout  = cout_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_add_slice_sequencer.sv
// Bench for add_slice_sequencer: a 12-bit and a 3-bit instance, each wired to a
// behavioural 3-bit adder, checked against plain whole-word arithmetic.
module tb_add_slice_sequencer;

   localparam int W  = 12;
   localparam int S  = W / 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   int            cyc = 0;
   int            total = 0;
   int            bad = 0;
   int            last_acc = 0;
   logic [W:0]    exp_q[$];

   // 12-bit instance signals
   logic          in_valid = 1'b0, in_ready, in_cin = 1'b0;
   logic [W-1:0]  in_a = '0, in_b = '0, out_sum;
   logic          out_valid, out_ready = 1'b0, out_cout;
   logic [2:0]    add_a, add_b, add_s;
   logic          add_cin, add_cout;
   logic [1:0]    dbg_state;

   // 3-bit instance signals
   logic          in_valid3 = 1'b0, in_ready3, in_cin3 = 1'b0;
   logic [2:0]    in_a3 = '0, in_b3 = '0, out_sum3;
   logic          out_valid3, out_ready3 = 1'b0, out_cout3;
   logic [2:0]    add_a3, add_b3, add_s3;
   logic          add_cin3, add_cout3;
   logic [1:0]    dbg_state3;

   // clock / reset block
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // external 3-bit ripple adders
   assign {add_cout, add_s}   = {1'b0, add_a} + {1'b0, add_b} + {3'b000, add_cin};
   assign {add_cout3, add_s3} = {1'b0, add_a3} + {1'b0, add_b3} + {3'b000, add_cin3};

   add_slice_sequencer #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s),
      .add_cout(add_cout), .dbg_state(dbg_state)
   );

   add_slice_sequencer #(.WIDTH(3)) dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
      .in_a(in_a3), .in_b(in_b3), .in_cin(in_cin3), .out_valid(out_valid3),
      .out_ready(out_ready3), .out_sum(out_sum3), .out_cout(out_cout3),
      .add_a(add_a3), .add_b(add_b3), .add_cin(add_cin3), .add_s(add_s3),
      .add_cout(add_cout3), .dbg_state(dbg_state3)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // carry entering slice k of a + b + cin, from whole-number arithmetic
   function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input int k);
      longint m, t;
      m = (longint'(1) << (3 * k)) - 1;
      t = (longint'(a) & m) + (longint'(b) & m) + longint'(cin);
      return logic'((t >> (3 * k)) & 1);
   endfunction

   // driver: one request on the 12-bit instance, with optional backpressure,
   // operand disturbance after acceptance and issue-interval check
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input int hold, input bit toggle, input bit chk_gap, input int gap);
      int n;
      logic [W:0] e;
      n = 0;
      while (!in_ready && n < 20) begin step(); n++; end
      check_eq("in_ready_wait", 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
      step();
      if (chk_gap) check_eq("issue_gap", 32'(cyc - last_acc), 32'(gap));
      last_acc = cyc;
      in_valid = 1'b0;
      exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
      if (toggle) begin
         in_a = ~a; in_b = W'($urandom); in_cin = ~cin;
      end
      for (int k = 0; k < S; k++) begin
         check_eq("run_out_valid", 32'(out_valid), 32'd0);
         check_eq("run_in_ready", 32'(in_ready), 32'd0);
         check_eq("run_add_a", 32'(add_a), 32'(a[3*k +: 3]));
         check_eq("run_add_b", 32'(add_b), 32'(b[3*k +: 3]));
         check_eq("run_add_cin", 32'(add_cin), 32'(carry_into(a, b, cin, k)));
         step();
      end
      check_eq("latency_valid", 32'(out_valid), 32'd1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check_eq("out_sum", 32'(out_sum), 32'(e[W-1:0]));
      check_eq("out_cout", 32'(out_cout), 32'(e[W]));
      check_eq("done_add_a", 32'({add_a, add_b, add_cin}), 32'd0);
      out_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         step();
         check_eq("hold_valid", 32'(out_valid), 32'd1);
         check_eq("hold_in_ready", 32'(in_ready), 32'd0);
         check_eq("hold_sum", 32'(out_sum), 32'(e[W-1:0]));
         check_eq("hold_cout", 32'(out_cout), 32'(e[W]));
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check_eq("post_valid", 32'(out_valid), 32'd0);
      check_eq("post_in_ready", 32'(in_ready), 32'd1);
      check_eq("post_sum_held", 32'(out_sum), 32'(e[W-1:0]));
   endtask

   // driver: one request on the 3-bit instance (single slice, latency 1)
   task automatic run_op3(input logic [2:0] a, input logic [2:0] b, input logic cin);
      logic [3:0] e;
      int n;
      n = 0;
      while (!in_ready3 && n < 20) begin step(); n++; end
      check_eq("w3_in_ready", 32'(in_ready3), 32'd1);
      in_valid3 = 1'b1; in_a3 = a; in_b3 = b; in_cin3 = cin;
      step();
      in_valid3 = 1'b0; in_a3 = ~a; in_cin3 = ~cin;
      e = {1'b0, a} + {1'b0, b} + {3'b000, cin};
      check_eq("w3_run_valid", 32'(out_valid3), 32'd0);
      check_eq("w3_add_cin", 32'(add_cin3), 32'(cin));
      step();
      check_eq("w3_latency_valid", 32'(out_valid3), 32'd1);
      check_eq("w3_sum", 32'(out_sum3), 32'(e[2:0]));
      check_eq("w3_cout", 32'(out_cout3), 32'(e[3]));
      out_ready3 = 1'b1;
      step();
      out_ready3 = 1'b0;
      check_eq("w3_post_valid", 32'(out_valid3), 32'd0);
   endtask

   initial begin
      // reset state
      rst = 1'b1;
      repeat (3) step();
      check_eq("rst_in_ready", 32'(in_ready), 32'd0);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_out_sum", 32'(out_sum), 32'd0);
      check_eq("rst_out_cout", 32'(out_cout), 32'd0);
      check_eq("rst_add", 32'({add_a, add_b, add_cin}), 32'd0);
      rst = 1'b0;
      #1;
      check_eq("rst_release_ready", 32'(in_ready), 32'd1);

      // directed cases
      run_op(12'hFFF, 12'h001, 1'b0, 0, 1'b0, 1'b0, 0);
      run_op(12'h123, 12'h456, 1'b1, 0, 1'b0, 1'b0, 0);
      run_op(12'hABC, 12'h789, 1'b1, 5, 1'b0, 1'b0, 0);
      run_op(12'h800, 12'h800, 1'b0, 0, 1'b0, 1'b0, 0);
      run_op(12'h7FF, 12'h000, 1'b0, 0, 1'b0, 1'b1, S + 2);
      run_op(12'h5A5, 12'h3C3, 1'b0, 0, 1'b1, 1'b1, S + 2);

      // reset in RUN at slice index 2
      in_valid = 1'b1; in_a = 12'hFFF; in_b = 12'hFFF; in_cin = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      check_eq("abort_in_ready_rst", 32'(in_ready), 32'd0);
      check_eq("abort_out_valid", 32'(out_valid), 32'd0);
      check_eq("abort_out_sum", 32'(out_sum), 32'd0);
      check_eq("abort_add", 32'({add_a, add_b, add_cin}), 32'd0);
      rst = 1'b0;
      #1;
      check_eq("abort_in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < S + 2; i++) begin
         step();
         check_eq("abort_no_valid", 32'(out_valid), 32'd0);
      end

      // randomized traffic
      for (int i = 0; i < 30; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, 0);
      end

      // 3-bit instance
      run_op3(3'h7, 3'h7, 1'b1);
      for (int i = 0; i < 10; i++) begin
         run_op3(3'($urandom), 3'($urandom), 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
